module_switch_debounce: RTL and testbench

// Input-conditioning stage between the board switches and the Hamming

---
 rtl/module_switch_debounce.sv | 93 +++++++++
 tb/tb_module_switch_debounce.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/module_switch_debounce.sv
// rtl/module_switch_debounce.sv - per-bit two-flop synchroniser, debouncer and edge strobe generator
module module_switch_debounce #(
  parameter int               WIDTH         = 13,
  parameter int               STABLE_CYCLES = 270000,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  // A zero-length stable window has no meaning; refuse to elaborate.
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("module_switch_debounce: STABLE_CYCLES must be >= 1");
  end

  localparam int             CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  CONE = CW'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sw_out;
  logic [WIDTH-1:0] r_sw_rise;
  logic [WIDTH-1:0] r_sw_fall;
  logic             r_any_change;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_differs;
  logic [WIDTH-1:0] w_qualify;

  // Per-bit decision: a bit qualifies when it has disagreed for the full window.
  always_comb begin
    w_differs = r_sync2 ^ r_sw_out;
    w_qualify = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_qualify[i] = w_differs[i] && (r_cnt[i] == CMAX);
    end
  end

  // Two-flop synchroniser; nothing sits between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counters: any agreeing cycle discards all accumulated credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_differs[i] || w_qualify[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CONE;
        end
      end
    end
  end

  // Accept qualified levels and register the matching one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_out     <= RESET_VALUE;
      r_sw_rise    <= '0;
      r_sw_fall    <= '0;
      r_any_change <= 1'b0;
    end else begin
      r_sw_out     <= r_sw_out ^ w_qualify;
      r_sw_rise    <= w_qualify & r_sync2;
      r_sw_fall    <= w_qualify & ~r_sync2;
      r_any_change <= |w_qualify;
    end
  end

  assign sw_out     = r_sw_out;
  assign sw_rise    = r_sw_rise;
  assign sw_fall    = r_sw_fall;
  assign any_change = r_any_change;

endmodule

// File: tb/tb_module_switch_debounce.sv
// tb/tb_module_switch_debounce.sv - randomized and directed bench for module_switch_debounce
module tb_module_switch_debounce;

  localparam int W  = 13;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  // Reference model: a level is accepted once the last SC synchronised samples all differ from it.
  logic [W-1:0] hist [$];
  logic [W-1:0] m_out;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  module_switch_debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(SC),
    .RESET_VALUE('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] v);
    logic [W-1:0] flip;
    flip = '1;
    if (hist.size() < SC + 1) begin
      flip = '0;
    end else begin
      for (int j = 2; j <= SC + 1; j++) begin
        flip &= hist[hist.size() - j] ^ m_out;
      end
    end
    m_rise = flip & ~m_out;
    m_fall = flip & m_out;
    m_out  = m_out ^ flip;
    hist.push_back(v);
    if (hist.size() > SC + 2) void'(hist.pop_front());
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"}, sw_out, m_out);
    chk({tag, "_rise"}, sw_rise, m_rise);
    chk({tag, "_fall"}, sw_fall, m_fall);
    chk({tag, "_any"}, {{(W-1){1'b0}}, any_change}, {{(W-1){1'b0}}, |(m_rise | m_fall)});
  endtask

  task automatic cycle(input logic [W-1:0] v, input string tag);
    sw_in = v;
    @(posedge clk);
    if (!rst) model_edge(v);
    @(negedge clk);
    check_all(tag);
  endtask

  // Called at a negedge; asserts reset, holds it for n edges, releases at a negedge.
  task automatic pulse_reset(input int n, input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_rst"});
    chk({tag, "_rst_out0"}, sw_out, '0);
    @(negedge clk);
    for (int i = 0; i < n; i++) cycle(sw_in, {tag, "_inrst"});
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    rst   = 1'b1;
    sw_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("init");
    rst = 1'b0;

    // 1: reset with all switches high, full-width rise after six edges
    sw_in = 13'h1FFF;
    pulse_reset(2, "t1");
    for (int i = 1; i <= 7; i++) begin
      cycle(13'h1FFF, "t1");
      if (i < 6) chk("t1_wait", sw_out, '0);
      if (i == 6) begin
        chk("t1_out6", sw_out, 13'h1FFF);
        chk("t1_rise6", sw_rise, 13'h1FFF);
        chk("t1_any6", {12'b0, any_change}, 13'h0001);
      end
      if (i == 7) chk("t1_rise7", sw_rise, '0);
    end

    // 2: clean rise of bit 0
    sw_in = '0;
    pulse_reset(1, "t2");
    repeat (3) cycle('0, "t2_idle");
    for (int i = 1; i <= 7; i++) begin
      cycle(13'h0001, "t2");
      if (i < 6) chk("t2_wait", sw_out, '0);
      if (i == 6) begin
        chk("t2_out6", sw_out, 13'h0001);
        chk("t2_rise6", sw_rise, 13'h0001);
        chk("t2_fall6", sw_fall, '0);
      end
    end

    // 3: bit 5 bouncing 1,1,1,0 never qualifies
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        cycle((i == 3) ? 13'h0001 : 13'h0021, "t3");
        chk("t3_out5", {12'b0, sw_out[5]}, '0);
        chk("t3_rise", sw_rise, '0);
      end
    end
    repeat (2) cycle(13'h0001, "t3_tail");

    // 4: bits 3:0 and 12 change together
    for (int i = 1; i <= 7; i++) begin
      cycle(13'h100E, "t4");
      if (i == 6) begin
        chk("t4_out6", sw_out, 13'h100E);
        chk("t4_rise6", sw_rise, 13'h100E);
        chk("t4_fall6", sw_fall, 13'h0001);
        chk("t4_any6", {12'b0, any_change}, 13'h0001);
      end
      if (i == 7) chk("t4_any7", {12'b0, any_change}, '0);
    end

    // 5: bit 7 high then falling
    repeat (8) cycle(13'h108E, "t5_up");
    for (int i = 1; i <= 7; i++) begin
      cycle(13'h100E, "t5");
      if (i == 6) begin
        chk("t5_fall6", sw_fall, 13'h0080);
        chk("t5_rise6", sw_rise, '0);
      end
    end

    // 6: reset in the middle of a bit-2 qualification
    sw_in = '0;
    pulse_reset(1, "t6a");
    repeat (8) cycle('0, "t6_idle");
    repeat (2) cycle(13'h0004, "t6_pre");
    pulse_reset(2, "t6");
    for (int i = 1; i <= 7; i++) begin
      cycle(13'h0004, "t6");
      if (i < 6) chk("t6_wait", sw_out, '0);
      if (i == 6) chk("t6_out6", sw_out, 13'h0004);
    end

    // Randomized: sparse toggles, bounce bursts and occasional resets
    v = sw_in;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset($urandom_range(1, 3), "rnd");
      end
      if ($urandom_range(0, 3) == 0) v = v ^ (13'h0001 << $urandom_range(0, W-1));
      if ($urandom_range(0, 49) == 0) v = W'($urandom);
      cycle(v, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
